// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard scheduler.
//   fwd_sel_t     : EX operand source select (regfile / EX-MEM / MEM-WB)
//   stage_entry_t : what the scheduler remembers about an in-flight instruction
//   REG_ZERO      : hard-wired zero register, never a forwarding/hazard source
//   selectFwd     : priority encoder for the forward select, younger wins
// -----------------------------------------------------------------------------
package hazard_pkg;

  // Width of a register address held in a stage entry. The top-level REG_AW
  // parameter must stay equal to this.
  localparam int ENTRY_AW = 5;

  localparam logic [ENTRY_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [ENTRY_AW-1:0] dst;
    logic                regwrite;
    logic                memread;
  } stage_entry_t;

  // The EX-stage producer is younger than the MEM-stage one, so its result
  // is the architecturally current value and takes priority.
  function automatic fwd_sel_t selectFwd(input logic exHit, input logic memHit);
    if (exHit) begin
      return FWD_EXMEM;
    end else if (memHit) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_sched_ctrl_dst_match.sv
// -----------------------------------------------------------------------------
// dst_match
// Compares one in-flight stage entry against one ID source operand.
//   entry : stage entry {valid, dst, regwrite, memread}
//   addr  : ID source register address
//   used  : the ID instruction actually reads this source
//   hit   : entry will write the register being read (never for register 0)
// -----------------------------------------------------------------------------
module dst_match
  import hazard_pkg::*;
(
  input  stage_entry_t        entry,
  input  logic [ENTRY_AW-1:0] addr,
  input  logic                used,
  output logic                hit
);

  // Whether the producer is a load only matters for load-use detection,
  // which the top handles; it is not part of the address match.
  logic unusedMemread;
  assign unusedMemread = entry.memread;

  assign hit = used & entry.valid & entry.regwrite &
               (entry.dst != REG_ZERO) & (entry.dst == addr);

endmodule

// File: rtl/hazard_sched_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_sched_ctrl
// Hazard scheduler for the 5-stage core, sitting beside the ID/EX boundary.
// Tracks destination registers in EX/MEM/WB, raises stall/bubble for load-use
// hazards, holds EX for multi-cycle ops and registers EX forward selects.
//   clk, reset_n          : clock, synchronous active-low reset
//   id_valid              : valid instruction in ID
//   id_rs/id_rt           : source addresses, id_rs_used/id_rt_used qualify them
//   id_dst/id_regwrite    : destination and write enable of the ID instruction
//   id_memread/id_multi   : ID instruction is a load / a multi-cycle EX op
//   stall                 : hold PC and IF/ID (combinational)
//   bubble                : load NOP into ID/EX (combinational)
//   ex_hold               : freeze ID/EX, NOP into EX/MEM (combinational)
//   mul_busy              : multi-cycle op occupying EX (registered)
//   fwd_a/fwd_b           : EX operand A/B source select (registered)
// -----------------------------------------------------------------------------
module hazard_sched_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_multi,
  output logic              stall,
  output logic              bubble,
  output logic              ex_hold,
  output logic              mul_busy,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam int              CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  stage_entry_t    exReg, memReg, wbReg;
  stage_entry_t    exNext, memNext, wbNext, idEntry;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic            mulBusyReg;
  fwd_sel_t        fwdAReg, fwdBReg, fwdANext, fwdBNext;

  logic [1:0] srcUsed;
  logic [1:0] exHit, memHit;
  logic [ENTRY_AW-1:0] srcAddr [2];

  logic busy, loadUse, issue;

  // WB-stage content is consulted only by the downstream regfile bypass.
  logic unusedWb;
  assign unusedWb = ^wbReg;

  assign srcAddr[0] = id_rs;
  assign srcAddr[1] = id_rt;
  assign srcUsed    = {id_rt_used, id_rs_used};

  // Index 0 = source A (rs), index 1 = source B (rt).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gSrc
      dst_match uExMatch (
        .entry(exReg),
        .addr (srcAddr[gi]),
        .used (srcUsed[gi]),
        .hit  (exHit[gi])
      );
      dst_match uMemMatch (
        .entry(memReg),
        .addr (srcAddr[gi]),
        .used (srcUsed[gi]),
        .hit  (memHit[gi])
      );
    end
  endgenerate

  // Hazard detection and combinational controls.
  assign busy    = (cntReg != '0);
  assign loadUse = id_valid & exReg.memread & (|exHit);
  assign ex_hold = busy;
  assign stall   = busy | loadUse;
  // A busy EX already freezes ID/EX, so the load-use bubble is suppressed.
  assign bubble  = loadUse & ~busy;
  assign issue   = id_valid & ~stall;

  always_comb begin
    idEntry          = '0;
    idEntry.valid    = 1'b1;
    idEntry.dst      = id_dst;
    idEntry.regwrite = id_regwrite;
    idEntry.memread  = id_memread;
  end

  // Next-state for the tracked pipeline, the occupancy counter and the
  // forward selects.
  always_comb begin
    exNext   = exReg;
    memNext  = memReg;
    wbNext   = memReg;
    cntNext  = cntReg;
    fwdANext = fwdAReg;
    fwdBNext = fwdBReg;

    if (busy) begin
      // Multi-cycle op stays in EX; a NOP drains into MEM behind it.
      memNext = '0;
      cntNext = cntReg - CNT_W'(1);
    end else begin
      memNext = exReg;
      exNext  = issue ? idEntry : '0;
      // Counter is only ever loaded from zero, so it cannot wrap.
      if (issue && id_multi) begin
        cntNext = CNT_LOAD;
      end
    end

    // Selects are computed against the entries as they stand before the
    // edge: the current EX instruction will be in EX/MEM when this one
    // executes, the current MEM one in MEM/WB.
    if (issue) begin
      fwdANext = selectFwd(exHit[0], memHit[0]);
      fwdBNext = selectFwd(exHit[1], memHit[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exReg      <= '0;
      memReg     <= '0;
      wbReg      <= '0;
      cntReg     <= '0;
      mulBusyReg <= 1'b0;
      fwdAReg    <= FWD_RF;
      fwdBReg    <= FWD_RF;
    end else begin
      exReg      <= exNext;
      memReg     <= memNext;
      wbReg      <= wbNext;
      cntReg     <= cntNext;
      mulBusyReg <= (cntNext != '0);
      fwdAReg    <= fwdANext;
      fwdBReg    <= fwdBNext;
    end
  end

  assign mul_busy = mulBusyReg;
  assign fwd_a    = fwdAReg;
  assign fwd_b    = fwdBReg;

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_sched_ctrl
// Directed stimulus for the hazard scheduler. A behavioural model of the
// in-flight instructions predicts every output each cycle; hand-computed
// literal expectations pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_hazard_sched_ctrl;

  localparam int MUL_LAT = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_rs_used = 1'b0;
  logic       id_rt_used = 1'b0;
  logic [4:0] id_dst = '0;
  logic       id_regwrite = 1'b0;
  logic       id_memread = 1'b0;
  logic       id_multi = 1'b0;
  logic       stall, bubble, ex_hold, mul_busy;
  logic [1:0] fwd_a, fwd_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_sched_ctrl #(.REG_AW(5), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_dst     (id_dst),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .id_multi   (id_multi),
    .stall      (stall),
    .bubble     (bubble),
    .ex_hold    (ex_hold),
    .mul_busy   (mul_busy),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  // ---------------- instruction helpers ----------------
  typedef struct {
    bit v;
    int rs;
    int rt;
    bit rsU;
    bit rtU;
    int dst;
    bit wr;
    bit ld;
    bit mul;
  } instr_t;

  function automatic instr_t nop();
    instr_t i;
    i = '{v:0, rs:0, rt:0, rsU:0, rtU:0, dst:0, wr:0, ld:0, mul:0};
    return i;
  endfunction

  function automatic instr_t alu(input int d, input int s, input int t);
    instr_t i;
    i = '{v:1, rs:s, rt:t, rsU:1, rtU:1, dst:d, wr:1, ld:0, mul:0};
    return i;
  endfunction

  function automatic instr_t load(input int d, input int s);
    instr_t i;
    i = '{v:1, rs:s, rt:0, rsU:1, rtU:0, dst:d, wr:1, ld:1, mul:0};
    return i;
  endfunction

  function automatic instr_t mulOp(input int d, input int s, input int t);
    instr_t i;
    i = '{v:1, rs:s, rt:t, rsU:1, rtU:1, dst:d, wr:1, ld:0, mul:1};
    return i;
  endfunction

  // Reads only rs; rt carries an address that must be ignored.
  function automatic instr_t readA(input int d, input int s, input int t);
    instr_t i;
    i = '{v:1, rs:s, rt:t, rsU:1, rtU:0, dst:d, wr:1, ld:0, mul:0};
    return i;
  endfunction

  // ---------------- behavioural model ----------------
  // The model remembers what each older instruction writes and how many
  // more cycles the multi-cycle op keeps EX occupied.
  typedef struct {
    bit v;
    int dst;
    bit wr;
    bit ld;
  } ment_t;

  ment_t mEx = '{v:0, dst:0, wr:0, ld:0};
  ment_t mMem = '{v:0, dst:0, wr:0, ld:0};
  int    mRemain = 0;
  int    mFwdA = 0;
  int    mFwdB = 0;
  bit    modelValid = 0;

  function automatic bit mWrites(input ment_t e, input int r);
    return e.v && e.wr && (e.dst != 0) && (e.dst == r);
  endfunction

  function bit mBusy();
    return mRemain > 0;
  endfunction

  function bit mLoadUse();
    return id_valid && mEx.ld &&
           ((mWrites(mEx, int'(id_rs)) && id_rs_used) ||
            (mWrites(mEx, int'(id_rt)) && id_rt_used));
  endfunction

  function bit mIssue();
    return id_valid && !mBusy() && !mLoadUse();
  endfunction

  function int mSel(input int r, input bit used);
    if (!used) return 0;
    if (mWrites(mEx, r)) return 1;
    if (mWrites(mMem, r)) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      mEx        <= '{v:0, dst:0, wr:0, ld:0};
      mMem       <= '{v:0, dst:0, wr:0, ld:0};
      mRemain    <= 0;
      mFwdA      <= 0;
      mFwdB      <= 0;
      modelValid <= 1;
    end else if (mBusy()) begin
      mMem    <= '{v:0, dst:0, wr:0, ld:0};
      mRemain <= mRemain - 1;
    end else begin
      if (mIssue()) begin
        mFwdA <= mSel(int'(id_rs), id_rs_used);
        mFwdB <= mSel(int'(id_rt), id_rt_used);
        mEx   <= '{v:1, dst:int'(id_dst), wr:id_regwrite, ld:id_memread};
        if (id_multi) mRemain <= MUL_LAT - 1;
      end else begin
        mEx <= '{v:0, dst:0, wr:0, ld:0};
      end
      mMem <= mEx;
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      chk("model_stall",    {1'b0, stall},    {1'b0, mBusy() || mLoadUse()});
      chk("model_bubble",   {1'b0, bubble},   {1'b0, mLoadUse() && !mBusy()});
      chk("model_ex_hold",  {1'b0, ex_hold},  {1'b0, mBusy()});
      chk("model_mul_busy", {1'b0, mul_busy}, {1'b0, mBusy()});
      chk("model_fwd_a",    fwd_a,            2'(mFwdA));
      chk("model_fwd_b",    fwd_b,            2'(mFwdB));
    end
  end

  // ---------------- stimulus ----------------
  // Presents one instruction for one cycle and returns at the following
  // falling edge so the caller can check its effect.
  task automatic cyc(input instr_t i, input bit rn = 1'b1);
    @(posedge clk);
    #1;
    reset_n     = rn;
    id_valid    = i.v;
    id_rs       = 5'(i.rs);
    id_rt       = 5'(i.rt);
    id_rs_used  = i.rsU;
    id_rt_used  = i.rtU;
    id_dst      = 5'(i.dst);
    id_regwrite = i.wr;
    id_memread  = i.ld;
    id_multi    = i.mul;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) cyc(nop());
  endtask

  initial begin
    // Reset
    cyc(nop(), 1'b0);
    cyc(nop(), 1'b1);
    chk("lit_rst_stall",    {1'b0, stall},    2'b00);
    chk("lit_rst_bubble",   {1'b0, bubble},   2'b00);
    chk("lit_rst_ex_hold",  {1'b0, ex_hold},  2'b00);
    chk("lit_rst_mul_busy", {1'b0, mul_busy}, 2'b00);
    chk("lit_rst_fwd_a",    fwd_a,            2'b00);
    chk("lit_rst_fwd_b",    fwd_b,            2'b00);
    drain();

    // ALU -> ALU: no stall, EX/MEM forward on A
    cyc(alu(3, 1, 2));
    cyc(alu(6, 3, 1));
    chk("lit_alu_stall", {1'b0, stall}, 2'b00);
    cyc(nop());
    chk("lit_alu_fwd_a", fwd_a, 2'b01);
    chk("lit_alu_fwd_b", fwd_b, 2'b00);
    drain();

    // Load-use: one bubble, then MEM/WB forward on B
    cyc(load(5, 1));
    cyc(alu(8, 2, 5));
    chk("lit_lu_stall",   {1'b0, stall},   2'b01);
    chk("lit_lu_bubble",  {1'b0, bubble},  2'b01);
    chk("lit_lu_ex_hold", {1'b0, ex_hold}, 2'b00);
    cyc(alu(8, 2, 5));
    chk("lit_lu_stall2",  {1'b0, stall},   2'b00);
    chk("lit_lu_bubble2", {1'b0, bubble},  2'b00);
    cyc(nop());
    chk("lit_lu_fwd_a", fwd_a, 2'b00);
    chk("lit_lu_fwd_b", fwd_b, 2'b10);
    drain();

    // Register 0 never creates a hazard or a forward
    cyc(load(0, 1));
    cyc(alu(12, 0, 0));
    chk("lit_r0_load_stall",  {1'b0, stall},  2'b00);
    chk("lit_r0_load_bubble", {1'b0, bubble}, 2'b00);
    cyc(alu(0, 1, 1));
    chk("lit_r0_load_fwd_a", fwd_a, 2'b00);
    chk("lit_r0_load_fwd_b", fwd_b, 2'b00);
    cyc(alu(13, 0, 0));
    chk("lit_r0_alu_stall", {1'b0, stall}, 2'b00);
    cyc(nop());
    chk("lit_r0_alu_fwd_a", fwd_a, 2'b00);
    chk("lit_r0_alu_fwd_b", fwd_b, 2'b00);
    drain();

    // Two producers of $4: the younger (EX) wins; unused rt gives 00
    cyc(alu(4, 1, 2));
    cyc(alu(4, 2, 3));
    cyc(readA(10, 4, 4));
    chk("lit_young_stall", {1'b0, stall}, 2'b00);
    cyc(nop());
    chk("lit_young_fwd_a", fwd_a, 2'b01);
    chk("lit_young_fwd_b", fwd_b, 2'b00);
    drain();

    // Multi-cycle op: exactly MUL_LAT-1 hold cycles, then EX/MEM forward
    cyc(mulOp(7, 1, 2));
    chk("lit_mul_issue_stall", {1'b0, stall}, 2'b00);
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      cyc(readA(11, 7, 0));
      chk("lit_mul_stall",    {1'b0, stall},    2'b01);
      chk("lit_mul_ex_hold",  {1'b0, ex_hold},  2'b01);
      chk("lit_mul_busy",     {1'b0, mul_busy}, 2'b01);
      chk("lit_mul_bubble",   {1'b0, bubble},   2'b00);
    end
    cyc(readA(11, 7, 0));
    chk("lit_mul_end_stall", {1'b0, stall},    2'b00);
    chk("lit_mul_end_busy",  {1'b0, mul_busy}, 2'b00);
    cyc(nop());
    chk("lit_mul_fwd_a", fwd_a, 2'b01);
    drain();

    // Reset while a multi-cycle op is in EX aborts it
    cyc(mulOp(9, 1, 2));
    cyc(nop(), 1'b0);
    chk("lit_abort_busy_before", {1'b0, mul_busy}, 2'b01);
    cyc(readA(14, 9, 0));
    chk("lit_abort_stall",    {1'b0, stall},    2'b00);
    chk("lit_abort_bubble",   {1'b0, bubble},   2'b00);
    chk("lit_abort_ex_hold",  {1'b0, ex_hold},  2'b00);
    chk("lit_abort_mul_busy", {1'b0, mul_busy}, 2'b00);
    chk("lit_abort_fwd_a",    fwd_a,            2'b00);
    chk("lit_abort_fwd_b",    fwd_b,            2'b00);
    cyc(nop());
    chk("lit_abort_issue_fwd_a", fwd_a, 2'b00);
    chk("lit_abort_no_stall",    {1'b0, stall}, 2'b00);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
